// File: rtl/ram_rd_stream.sv
// ram_rd_stream: streams a burst of words out of a RAM that has a fixed
// two-cycle read latency. Addresses are issued only while the 4-entry output
// FIFO plus the reads still in flight leave room. Because of that limit the
// FIFO can never overflow, even when the downstream stalls for a long time.
module ram_rd_stream #(
    parameter int C_DAT_W = 72,
    parameter int C_ADR_W = 10
) (
    input  logic               CK_i,
    input  logic               SRST_i,
    input  logic               START_i,
    input  logic [C_ADR_W-1:0] BASE_As_i,
    input  logic [C_ADR_W-1:0] LEN_i,
    output logic [C_ADR_W-1:0] RAs_o,
    input  logic [C_DAT_W-1:0] RDs_i,
    output logic [C_DAT_W-1:0] DAT_o,
    output logic               VLD_o,
    input  logic               RDY_i,
    output logic               BUSY_o,
    output logic               DONE_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [C_ADR_W-1:0]   adr_q, adr_d;     // next address to issue
    logic [C_ADR_W-1:0]   rem_q, rem_d;     // addresses left to issue, minus one
    logic [C_ADR_W-1:0]   ras_q, ras_d;     // last issued address, held on RAs_o
    logic [1:0]           vs_q, vs_d;       // in-flight read valids, bit 1 = data on RDs_i now
    logic [2:0]           occ_q, occ_d;     // FIFO occupancy 0..4
    logic [1:0]           wr_ptr_q, rd_ptr_q;
    logic                 done_q, done_d;
    logic [C_DAT_W-1:0]   fifo_q [4];

    logic [1:0]           inflight;
    logic [2:0]           outstanding;
    logic                 issue;
    logic                 fifo_wr;
    logic                 xfer;

    // Room check: buffered words plus reads still returning must stay below 4.
    always_comb begin
        inflight    = {1'b0, vs_q[0]} + {1'b0, vs_q[1]};
        outstanding = occ_q + {1'b0, inflight};
        issue       = (state_q == S_RUN) && (outstanding < 3'd4);
        fifo_wr     = vs_q[1];
        VLD_o       = (occ_q != 3'd0);
        xfer        = VLD_o && RDY_i;
    end

    // Next-state logic for the burst sequencer and its counters.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        ras_d   = ras_q;
        done_d  = 1'b0;
        vs_d    = {vs_q[0], issue};
        occ_d   = occ_q + {2'b00, fifo_wr} - {2'b00, xfer};
        case (state_q)
            S_IDLE: begin
                if (START_i) begin
                    state_d = S_RUN;
                    adr_d   = BASE_As_i;
                    rem_d   = LEN_i;
                end
            end
            S_RUN: begin
                if (issue) begin
                    ras_d = adr_q;
                    adr_d = adr_q + 1'b1;   // wraps naturally at 2**C_ADR_W
                    if (rem_q == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        rem_d = rem_q - 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // The last word leaves when the FIFO holds only it and nothing is returning.
                if (xfer && (occ_q == 3'd1) && (vs_q == 2'b00)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers; reset drops everything, including buffered data.
    always_ff @(posedge CK_i) begin
        if (SRST_i) begin
            state_q  <= S_IDLE;
            adr_q    <= '0;
            rem_q    <= '0;
            ras_q    <= '0;
            vs_q     <= '0;
            occ_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            rem_q    <= rem_d;
            ras_q    <= ras_d;
            vs_q     <= vs_d;
            occ_q    <= occ_d;
            done_q   <= done_d;
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (xfer) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
        end
    end

    // FIFO storage, one write-enabled register per entry.
    for (genvar gi = 0; gi < 4; gi++) begin : g_fifo
        always_ff @(posedge CK_i) begin
            if (fifo_wr && (wr_ptr_q == 2'(gi))) begin
                fifo_q[gi] <= RDs_i;
            end
        end
    end

    // The address goes out directly in the cycle it issues; otherwise the last one is held.
    always_comb begin
        RAs_o  = issue ? adr_q : ras_q;
        DAT_o  = VLD_o ? fifo_q[rd_ptr_q] : '0;
        BUSY_o = (state_q != S_IDLE);
        DONE_o = done_q;
    end

endmodule

// File: tb/tb_ram_rd_stream.sv
// Bench for ram_rd_stream: a two-cycle RAM model, a queue of expected words
// per burst, and a per-cycle compare process, plus directed latency checks.
module tb_ram_rd_stream;
    localparam int DW = 72;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          srst, start, rdy;
    logic [AW-1:0] base, len, ras;
    logic [DW-1:0] rds, dat;
    logic          vld, busy, done;
    logic [DW-1:0] r1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int xfers   = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    logic [DW-1:0] exp_q[$];
    int            end_q[$];   // transfer count at which each open burst ends

    always #5 clk = ~clk;

    ram_rd_stream #(.C_DAT_W(DW), .C_ADR_W(AW)) dut (
        .CK_i(clk), .SRST_i(srst), .START_i(start), .BASE_As_i(base),
        .LEN_i(len), .RAs_o(ras), .RDs_i(rds), .DAT_o(dat), .VLD_o(vld),
        .RDY_i(rdy), .BUSY_o(busy), .DONE_o(done)
    );

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return {{(DW-AW){1'b0}}, a ^ 10'h055};
    endfunction

    // RAM with two cycles of read latency.
    always @(posedge clk) begin
        r1  <= mem_f(ras);
        rds <= r1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b0;
            endcase
        end
    end

    // Per-cycle scoreboard: stream data, stall stability, burst completion.
    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_dat;
        prev_stall = 1'b0;
        prev_dat   = '0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("hold_vld", {{(DW-1){1'b0}}, vld}, 1);
                check("hold_dat", dat, prev_dat);
            end
            if (vld && rdy) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_xfer: got word %0h expected none", dat);
                end else begin
                    check("data", dat, exp_q.pop_front());
                end
                xfers++;
            end
            if (done) begin
                if (end_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_open: got DONE_o=1 expected no open burst");
                end else begin
                    check("done_count", DW'(xfers), DW'(end_q.pop_front()));
                end
                check("done_busy", {{(DW-1){1'b0}}, busy}, 0);
            end
            prev_stall = vld && !rdy && !srst;
            prev_dat   = dat;
        end
    end

    task automatic flush_model();
        exp_q.delete();
        end_q.delete();
    endtask

    task automatic start_burst(input logic [AW-1:0] b, input logic [AW-1:0] l, output int t0);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = b;
        len   = l;
        t0    = cyc;
        for (int i = 0; i <= int'(l); i++) exp_q.push_back(mem_f(b + AW'(i)));
        end_q.push_back(xfers + exp_q.size());
        $display("[TB] burst start base=%03h len=%0d cycle=%0d", b, l, t0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                $display("[TB] burst done cycle=%0d transfers=%0d", cyc, xfers);
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL done_timeout: got no DONE_o expected within %0d cycles", budget);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ras"},  DW'(ras), 0);
        check({name, "_dat"},  dat, 0);
        check({name, "_vld"},  DW'(vld), 0);
        check({name, "_busy"}, DW'(busy), 0);
        check({name, "_done"}, DW'(done), 0);
    endtask

    initial begin
        int            t0;
        int            x0;
        logic          v  [1:15];
        logic          dn [1:15];
        logic          bz [1:15];
        logic [DW-1:0] d  [1:15];
        logic [AW-1:0] a  [1:15];

        srst = 1'b0; start = 1'b0; base = '0; len = '0;

        // Reset together with START: reset wins, design stays idle.
        @(posedge clk); #1;
        srst = 1'b1; start = 1'b1; base = 10'h155; len = 10'd3;
        @(posedge clk); #1;
        srst = 1'b0; start = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        check("reset_start_ignored", DW'(busy), 0);

        // Basic latency burst.
        rdy_mode = 0;
        start_burst(10'h010, 10'd3, t0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            v[k] = vld; d[k] = dat; dn[k] = done; bz[k] = busy; a[k] = ras;
        end
        check("lat_ras1",  DW'(a[1]), 'h010);
        check("lat_busy1", DW'(bz[1]), 1);
        check("lat_vld3",  DW'(v[3]), 0);
        check("lat_vld4",  DW'(v[4]), 1);
        check("lat_dat4",  d[4], 'h45);
        check("lat_dat5",  d[5], 'h44);
        check("lat_dat6",  d[6], 'h47);
        check("lat_dat7",  d[7], 'h46);
        check("lat_done7", DW'(dn[7]), 0);
        check("lat_done8", DW'(dn[8]), 1);
        check("lat_busy8", DW'(bz[8]), 0);
        check("lat_vld8",  DW'(v[8]), 0);

        // Address wrap at the top of the RAM.
        start_burst(10'h3FE, 10'd3, t0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            a[k] = ras;
        end
        check("wrap_ras1", DW'(a[1]), 'h3FE);
        check("wrap_ras2", DW'(a[2]), 'h3FF);
        check("wrap_ras3", DW'(a[3]), 'h000);
        check("wrap_ras4", DW'(a[4]), 'h001);
        wait_done(50);

        // Back-to-back: START during the DONE cycle opens a new burst.
        start_burst(10'h100, 10'd2, t0);
        for (int k = 1; k <= 6; k++) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1; base = 10'h200; len = 10'd1;
        for (int i = 0; i <= 1; i++) exp_q.push_back(mem_f(10'h200 + AW'(i)));
        end_q.push_back(xfers + exp_q.size());
        @(negedge clk);
        check("b2b_done7", DW'(done), 1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_busy8", DW'(busy), 1);
        wait_done(50);

        // Downstream stalled for cycles 0..15.
        rdy_mode = 2;
        start_burst(10'h123, 10'd7, t0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 5) begin
                check("stall_vld5", DW'(vld), 1);
                check("stall_dat5", dat, 'h176);
            end
        end
        check("stall_vld15", DW'(vld), 1);
        check("stall_dat15", dat, 'h176);
        check("stall_ras15", DW'(ras), 'h126);
        rdy_mode = 0;
        wait_done(100);

        // Full-RAM burst with random back-pressure.
        rdy_mode = 1;
        x0 = xfers;
        start_burst(10'($urandom_range(0, 1023)), 10'h3FF, t0);
        wait_done(10000);
        check("full_count", DW'(xfers - x0), 1024);

        // Reset in the cycle after the 3rd transfer (transfers in cycles 4..6).
        rdy_mode = 0;
        start_burst(10'h040, 10'd9, t0);
        for (int k = 1; k <= 6; k++) @(negedge clk);
        @(posedge clk); #1;
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        flush_model();
        @(negedge clk);
        check_all_zero("midrst");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("midrst_nodone", DW'(done), 0);
        end
        start_burst(10'h300, 10'd4, t0);
        wait_done(50);

        // START re-asserted mid-run with a different base is ignored.
        rdy_mode = 1;
        start_burst(10'h0A0, 10'd5, t0);
        @(posedge clk); #1;
        start = 1'b1; base = 10'h2F0; len = 10'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("ignored_idle_vld", DW'(vld), 0);
        end
        check("ignored_queue_empty", DW'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

endmodule
